dmem_arbiter: RTL

- Arbitrates the single-port 1024x64 data memory between two requesters: the pipeline memory stage (m_ port) and the program loader/debug port (l_ port).
- Sequences each access as issue, wait for memory latency, then respond. Performs the address range check and returns an error flag in place of a memory access when the address is out of range.
- Drives m_stall back to the pipeline hazard logic; the pipeline holds the M register while m_stall is high.

---
 rtl/dmem_arbiter_if.sv | 20 ++
 rtl/dmem_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: pipeline (m_) and loader (l_) request/response buses plus the memory port; slave = arbiter, master = requesters/memory
interface dmem_arbiter_if #(parameter int DW = 64, parameter int AW = 10);
  logic m_req, m_we, m_ack, m_err, m_stall;
  logic [63:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic l_req, l_we, l_ack, l_err;
  logic [63:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport slave (
    input m_req, m_we, m_addr, m_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output m_ack, m_rdata, m_err, m_stall, l_ack, l_rdata, l_err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output m_req, m_we, m_addr, m_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input m_ack, m_rdata, m_err, m_stall, l_ack, l_rdata, l_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates the data memory between pipeline and loader (ports: clk, reset, bus = dmem_arbiter_if.slave)
module dmem_arbiter #(
  parameter int DEPTH = 1024,
  parameter int DW = 64,
  parameter int MEM_LAT = 2,
  parameter int STARVE_LIM = 4
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic own_q, own_d, we_q, we_d, err_q, err_d, grant_l;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, m_rdata_q, m_rdata_d, l_rdata_q, l_rdata_d;
  logic [CW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [63:0] sel_addr;
  always_comb begin
    state_d = state_q;
    own_d = own_q;
    we_d = we_q;
    err_d = err_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    m_rdata_d = m_rdata_q;
    l_rdata_d = l_rdata_q;
    lat_d = lat_q;
    starve_d = starve_q;
    grant_l = bus.l_req && (!bus.m_req || starve_q == SW'(STARVE_LIM));
    sel_addr = grant_l ? bus.l_addr : bus.m_addr;
    case (state_q)
      IDLE: if (bus.m_req || bus.l_req) begin
        own_d = grant_l;
        we_d = grant_l ? bus.l_we : bus.m_we;
        addr_d = sel_addr[AW-1:0];
        wdata_d = grant_l ? bus.l_wdata : bus.m_wdata;
        err_d = sel_addr >= 64'(DEPTH);
        starve_d = (grant_l || !bus.l_req) ? '0 : starve_q + SW'(1);
        state_d = err_d ? DONE : ISSUE;
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        lat_d = CW'(MEM_LAT - 1);
      end
      WAIT: if (lat_q == '0) begin
        m_rdata_d = own_q ? m_rdata_q : bus.mem_rdata;
        l_rdata_d = own_q ? bus.mem_rdata : l_rdata_q;
        state_d = DONE;
      end else lat_d = lat_q - CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      own_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      m_rdata_q <= '0;
      l_rdata_q <= '0;
      lat_q <= '0;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      we_q <= we_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      m_rdata_q <= m_rdata_d;
      l_rdata_q <= l_rdata_d;
      lat_q <= lat_d;
      starve_q <= starve_d;
    end
  end
  assign bus.mem_en = state_q == ISSUE;
  assign bus.mem_we = bus.mem_en && we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.m_ack = state_q == DONE && !own_q;
  assign bus.l_ack = state_q == DONE && own_q;
  assign bus.m_err = bus.m_ack && err_q;
  assign bus.l_err = bus.l_ack && err_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.l_rdata = l_rdata_q;
  assign bus.m_stall = bus.m_req && !bus.m_ack;
endmodule
